// File: rtl/addr_seq_if.sv
// Request and address-stream bundle between the data-control FSM, the address
// sequencer and the memory port.
interface addr_seq_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 16
);
  logic              start;
  logic [1:0]        mode;
  logic [ADDR_W-1:0] offset;
  logic [CNT_W-1:0]  filesize;
  logic [ADDR_W-1:0] stride;
  logic              abort;
  logic              addr_ready;
  logic              addr_valid;
  logic [ADDR_W-1:0] addr;
  logic              addr_last;
  logic              busy;
  logic              done;
  logic              err;

  // Sequencer side
  modport master (
    input  start, mode, offset, filesize, stride, abort, addr_ready,
    output addr_valid, addr, addr_last, busy, done, err
  );

  // Controller / consumer side
  modport slave (
    output start, mode, offset, filesize, stride, abort, addr_ready,
    input  addr_valid, addr, addr_last, busy, done, err
  );
endinterface

// File: rtl/addr_seq_gen.sv
// Burst address sequencer: linear, bit-reversed (FFT) and strided address
// streams presented over a valid/ready handshake.
module addr_seq_gen #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned MAX_LOG2N = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  addr_seq_if.master   bus
);

  localparam int unsigned LOG_W = $clog2(MAX_LOG2N + 1);
  localparam int unsigned MAX_N = 1 << MAX_LOG2N;

  localparam logic [1:0] MODE_LIN = 2'd0;
  localparam logic [1:0] MODE_REV = 2'd1;
  localparam logic [1:0] MODE_STR = 2'd2;
  localparam logic [1:0] MODE_RSV = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [ADDR_W-1:0] offset_q, offset_d;
  logic [CNT_W-1:0]  filesize_q, filesize_d;
  logic [ADDR_W-1:0] stride_q, stride_d;
  logic [LOG_W-1:0]  log2_q, log2_d;
  logic [CNT_W-1:0]  index_q, index_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              addr_valid_q, addr_valid_d;
  logic              addr_last_q, addr_last_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [LOG_W-1:0]     log2_c;
  logic                 pow2_c;
  logic                 too_big_c;
  logic                 reject_c;
  logic                 xfer_c;
  logic [CNT_W-1:0]     idx_nxt_c;
  logic [MAX_LOG2N-1:0] rev_full_c;
  logic [MAX_LOG2N-1:0] rev_c;
  logic [ADDR_W-1:0]    addr_nxt_c;

  // Priority encoder on the requested size; only meaningful for powers of two
  always_comb begin
    log2_c = '0;
    for (int i = 0; i <= MAX_LOG2N; i++) begin
      if (bus.filesize[i]) log2_c = LOG_W'(i);
    end
  end

  assign pow2_c    = (bus.filesize != '0) &&
                     ((bus.filesize & (bus.filesize - CNT_W'(1))) == '0);
  assign too_big_c = bus.filesize > CNT_W'(MAX_N);
  assign reject_c  = (bus.mode == MODE_RSV) ||
                     ((bus.mode == MODE_REV) && (!pow2_c || too_big_c));
  assign xfer_c    = addr_valid_q && bus.addr_ready;

  // Reverse the full MAX_LOG2N-bit field, then shift down so only L bits remain
  assign idx_nxt_c  = index_q + CNT_W'(1);
  assign rev_full_c = {<<{idx_nxt_c[MAX_LOG2N-1:0]}};
  assign rev_c      = rev_full_c >> (LOG_W'(MAX_LOG2N) - log2_q);

  // Address for the following index; strided mode accumulates on addr_q
  always_comb begin
    addr_nxt_c = addr_q;
    case (mode_q)
      MODE_LIN: addr_nxt_c = offset_q + ADDR_W'(idx_nxt_c);
      MODE_REV: addr_nxt_c = offset_q + ADDR_W'(rev_c);
      MODE_STR: addr_nxt_c = addr_q + stride_q;
      default:  addr_nxt_c = addr_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      mode_q       <= '0;
      offset_q     <= '0;
      filesize_q   <= '0;
      stride_q     <= '0;
      log2_q       <= '0;
      index_q      <= '0;
      addr_q       <= '0;
      addr_valid_q <= 1'b0;
      addr_last_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      offset_q     <= offset_d;
      filesize_q   <= filesize_d;
      stride_q     <= stride_d;
      log2_q       <= log2_d;
      index_q      <= index_d;
      addr_q       <= addr_d;
      addr_valid_q <= addr_valid_d;
      addr_last_q  <= addr_last_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    offset_d     = offset_q;
    filesize_d   = filesize_q;
    stride_d     = stride_q;
    log2_d       = log2_q;
    index_d      = index_q;
    addr_d       = addr_q;
    addr_valid_d = addr_valid_q;
    addr_last_d  = addr_last_q;
    err_d        = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          mode_d     = bus.mode;
          offset_d   = bus.offset;
          filesize_d = bus.filesize;
          stride_d   = bus.stride;
          log2_d     = log2_c;
          index_d    = '0;
          addr_d     = bus.offset;
          if (bus.filesize == '0) begin
            state_d = FINISH;
          end else if (reject_c) begin
            err_d = 1'b1;
          end else begin
            state_d      = RUN;
            addr_valid_d = 1'b1;
            addr_last_d  = (bus.filesize == CNT_W'(1));
          end
        end
      end
      RUN: begin
        // Abort beats a concurrent final transfer: no done is produced
        if (bus.abort) begin
          state_d      = IDLE;
          addr_valid_d = 1'b0;
          addr_last_d  = 1'b0;
        end else if (xfer_c) begin
          if (addr_last_q) begin
            state_d      = FINISH;
            addr_valid_d = 1'b0;
            addr_last_d  = 1'b0;
          end else begin
            index_d     = idx_nxt_c;
            addr_d      = addr_nxt_c;
            addr_last_d = (idx_nxt_c == filesize_q - CNT_W'(1));
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d      = IDLE;
        addr_valid_d = 1'b0;
        addr_last_d  = 1'b0;
      end
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == FINISH);
  end

  assign bus.addr_valid = addr_valid_q;
  assign bus.addr       = addr_q;
  assign bus.addr_last  = addr_last_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;

endmodule
